// File: rtl/right_shift.sv
// Multi-cycle right shifter (SRL/SRA) for the execute stage.
// Shifts one bit per clock; busy/done are pure decodes of the state register.
module right_shift #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               arith,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               arith_q, arith_d;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            cnt_q    <= '0;
            arith_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            arith_q  <= arith_d;
        end
    end

    // Next-state logic: accept in idle, shift one bit per cycle, one-cycle done.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        arith_d  = arith_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    result_d = data_in;
                    cnt_d    = shamt;
                    arith_d  = arith;
                    state_d  = (shamt != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                // Fill from the current MSB so repeated steps match >>>.
                result_d = {arith_q & result_q[WIDTH-1], result_q[WIDTH-1:1]};
                cnt_d    = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        data_out = result_q;
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
    end

endmodule

// File: tb/tb_right_shift.sv
// Scoreboard bench for right_shift: stimulus pushes expected results with
// their due cycle; a monitor pops and compares whenever done is seen.
module tb_right_shift;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        arith;
    logic [4:0]  shamt;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   total    = 0;
    int   bad      = 0;

    right_shift #(
        .WIDTH  (32),
        .SHAMT_W(5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .arith   (arith),
        .shamt   (shamt),
        .data_in (data_in),
        .data_out(data_out),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt++;

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] n,
                                          input logic a);
        logic signed [31:0] s;
        s = d;
        if (a) return 32'(s >>> n);
        return d >> n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic rand_idle_inputs();
        data_in = $urandom;
        shamt   = 5'($urandom);
        arith   = 1'($urandom);
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=%h required=no-done (edge %0d)",
                         data_out, edge_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_data", data_out, e.val);
                chk("done_cycle", 32'(edge_cnt), 32'(e.due));
            end
        end
    end

    // Issue one request from an idle cycle; returns in the first idle cycle after done.
    task automatic run_op(input logic [31:0] d, input logic [4:0] n, input logic a);
        exp_t e;
        start   = 1'b1;
        data_in = d;
        shamt   = n;
        arith   = a;
        e.val   = model(d, n, a);
        e.due   = edge_cnt + 1 + int'(n);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        rand_idle_inputs();
        chk("busy_c1", 32'(busy), 32'd1);
        repeat (int'(n) + 1) begin
            @(negedge clk);
            rand_idle_inputs();
        end
        chk("busy_low", 32'(busy), 32'd0);
        chk("hold_data", data_out, e.val);
    endtask

    initial begin
        exp_t e;
        reset_n = 1'b0;
        start   = 1'($urandom);
        rand_idle_inputs();
        @(negedge clk);
        start = 1'($urandom);
        rand_idle_inputs();
        @(negedge clk);
        chk("rst_data", data_out, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        start   = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(32'h8000_0000, 5'd4, 1'b0);
        chk("srl_val", data_out, 32'h0800_0000);
        run_op(32'h8000_0000, 5'd31, 1'b1);
        chk("sra_neg", data_out, 32'hFFFF_FFFF);
        run_op(32'h7FFF_FFFF, 5'd31, 1'b1);
        chk("sra_pos", data_out, 32'h0000_0000);
        run_op(32'hDEAD_BEEF, 5'd0, 1'b1);
        chk("zero_shift", data_out, 32'hDEAD_BEEF);

        // Start while busy: attempts in cycles 2 and 9 (DONE) must be ignored
        start   = 1'b1;
        data_in = 32'h0000_F000;
        shamt   = 5'd8;
        arith   = 1'b0;
        e.val   = 32'h0000_00F0;
        e.due   = edge_cnt + 9;
        sb.push_back(e);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start   = (k == 2 || k == 9);
            data_in = 32'hFFFF_FFFF;
            shamt   = 5'd1;
            arith   = 1'b1;
        end
        start = 1'b0;
        chk("busy_ign_data", data_out, 32'h0000_00F0);
        chk("busy_ign_idle", 32'(busy), 32'd0);
        run_op(32'hA5A5_0000, 5'd3, 1'b1);

        // Reset mid-shift aborts without a done pulse
        start   = 1'b1;
        data_in = 32'h1234_5678;
        shamt   = 5'd20;
        arith   = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = 1'b0;
            rand_idle_inputs();
        end
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_data", data_out, 32'h0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        run_op(32'h1234_5678, 5'd20, 1'b0);

        // Randomized back-to-back and gapped requests
        for (int i = 0; i < 40; i++) begin
            run_op($urandom, 5'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (40) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
